// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline-stage buffers.
package pipe_pkg;

   localparam int PC_W   = 32;
   localparam int INST_W = 32;

   // RISC-V addi x0,x0,0 so a reset stage register looks like a bubble
   localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } buf_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, for performance debug.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (!rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc && (count != {W{1'b1}}))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry elastic stage register (main + skid) with registered ready,
// synchronous flush and stall/bubble counters.
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int               WIDTH      = 64,
   parameter logic [WIDTH-1:0] RESET_DATA = {WIDTH{1'b0}},
   parameter int               CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             cnt_clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt
);

   buf_state_e       state, state_nxt;
   logic [WIDTH-1:0] main_q, skid_q;
   logic             main_ld, main_from_skid, skid_ld;
   logic             in_fire, out_fire;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_comb begin
      state_nxt      = state;
      main_ld        = 1'b0;
      main_from_skid = 1'b0;
      skid_ld        = 1'b0;
      case (state)
         ST_EMPTY: begin
            if (in_fire) begin
               state_nxt = ST_BUSY;
               main_ld   = 1'b1;
            end
         end
         ST_BUSY: begin
            case ({in_fire, out_fire})
               2'b10: begin
                  state_nxt = ST_FULL;
                  skid_ld   = 1'b1;
               end
               2'b01: state_nxt = ST_EMPTY;
               2'b11: main_ld = 1'b1;
               default: ;
            endcase
         end
         ST_FULL: begin
            if (out_fire) begin
               state_nxt      = ST_BUSY;
               main_ld        = 1'b1;
               main_from_skid = 1'b1;
            end
         end
         default: state_nxt = ST_EMPTY;
      endcase
      // Squash drops any incoming beat; an outgoing beat already left.
      if (flush) begin
         state_nxt = ST_EMPTY;
         main_ld   = 1'b0;
         skid_ld   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ST_EMPTY;
         in_ready <= 1'b1;
         main_q   <= RESET_DATA;
         skid_q   <= RESET_DATA;
      end else begin
         state    <= state_nxt;
         in_ready <= (state_nxt != ST_FULL);
         if (main_ld)
            main_q <= main_from_skid ? skid_q : in_data;
         if (skid_ld)
            skid_q <= in_data;
      end
   end

   assign out_valid = (state != ST_EMPTY);
   assign out_data  = main_q;

   always_comb begin
      case (state)
         ST_BUSY: occupancy = 2'd1;
         ST_FULL: occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (out_valid & ~out_ready),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (~out_valid & out_ready),
      .count (bubble_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed vector bench for pipe_stage_buf with 4-bit counters.
module tb_pipe_stage_buf;
   import pipe_pkg::*;

   localparam int               WIDTH = 64;
   localparam int               CNT_W = 4;
   localparam logic [WIDTH-1:0] RD    = {{PC_W{1'b0}}, NOP_INST};

   logic             clk = 1'b0;
   logic             rst, flush, cnt_clr, in_valid, out_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_ready, out_valid;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       occupancy;
   logic [CNT_W-1:0] stall_cnt, bubble_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_stage_buf #(.WIDTH(WIDTH), .RESET_DATA(RD), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .cnt_clr    (cnt_clr),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .occupancy  (occupancy),
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt)
   );

   typedef struct {
      logic             rst, flush, clr, iv;
      logic [WIDTH-1:0] din;
      logic             ordy;
      logic             e_ir, e_ov;
      logic [1:0]       e_occ;
      logic [WIDTH-1:0] e_data;
      int               e_st, e_bb;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got %0h expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, input logic f, input logic c, input logic iv,
                      input logic [WIDTH-1:0] d, input logic ordy, input logic ir,
                      input logic ov, input logic [1:0] occ, input logic [WIDTH-1:0] data,
                      input int st, input int bb);
      vec_t v;
      v.rst = r; v.flush = f; v.clr = c; v.iv = iv; v.din = d; v.ordy = ordy;
      v.e_ir = ir; v.e_ov = ov; v.e_occ = occ; v.e_data = data; v.e_st = st; v.e_bb = bb;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic r, input logic f, input logic c, input logic iv,
                        input logic [WIDTH-1:0] d, input logic ordy);
      rst = r; flush = f; cnt_clr = c; in_valid = iv; in_data = d; out_ready = ordy;
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h77, 1'b0);
      #2;
      //   rst flush clr iv data    ordy | ir ov occ data    st bb
      // reset with in_valid asserted
      add(0, 0, 0, 1, 64'h77, 0,   1, 0, 0, RD,     0, 0);
      add(0, 0, 0, 1, 64'h77, 0,   1, 0, 0, RD,     0, 0);
      // streaming 1..5
      add(1, 0, 0, 1, 64'h1,  1,   1, 1, 1, 64'h1,  0, 1);
      add(1, 0, 0, 1, 64'h2,  1,   1, 1, 1, 64'h2,  0, 1);
      add(1, 0, 0, 1, 64'h3,  1,   1, 1, 1, 64'h3,  0, 1);
      add(1, 0, 0, 1, 64'h4,  1,   1, 1, 1, 64'h4,  0, 1);
      add(1, 0, 0, 1, 64'h5,  1,   1, 1, 1, 64'h5,  0, 1);
      add(1, 0, 0, 0, 64'h0,  1,   1, 0, 0, 64'h5,  0, 1);
      // backpressure A,B then drain in order
      add(1, 0, 0, 1, 64'hA,  0,   1, 1, 1, 64'hA,  0, 1);
      add(1, 0, 0, 1, 64'hB,  0,   0, 1, 2, 64'hA,  1, 1);
      add(1, 0, 0, 1, 64'hEE, 0,   0, 1, 2, 64'hA,  2, 1);
      add(1, 0, 0, 0, 64'h0,  0,   0, 1, 2, 64'hA,  3, 1);
      add(1, 0, 0, 0, 64'h0,  1,   1, 1, 1, 64'hB,  3, 1);
      add(1, 0, 0, 0, 64'h0,  1,   1, 0, 0, 64'hB,  3, 1);
      // fill to FULL, flush with in_valid carrying 0xC
      add(1, 0, 0, 1, 64'h10, 0,   1, 1, 1, 64'h10, 3, 1);
      add(1, 0, 0, 1, 64'h11, 0,   0, 1, 2, 64'h10, 4, 1);
      add(1, 1, 0, 1, 64'hC,  0,   1, 0, 0, 64'h10, 5, 1);
      add(1, 0, 0, 0, 64'h0,  1,   1, 0, 0, 64'h10, 5, 2);
      add(1, 0, 0, 1, 64'h12, 1,   1, 1, 1, 64'h12, 5, 3);
      add(1, 0, 0, 0, 64'h0,  1,   1, 0, 0, 64'h12, 5, 3);
      // flush from BUSY with both handshakes live
      add(1, 0, 0, 1, 64'h13, 0,   1, 1, 1, 64'h13, 5, 3);
      add(1, 1, 0, 1, 64'h14, 1,   1, 0, 0, 64'h13, 5, 3);
      // clear beats a pending bubble increment
      add(1, 0, 1, 0, 64'h0,  1,   1, 0, 0, 64'h13, 0, 0);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].flush, vecs[i].clr, vecs[i].iv, vecs[i].din, vecs[i].ordy);
         step();
         chk("in_ready",  i, 64'(in_ready),   64'(vecs[i].e_ir));
         chk("out_valid", i, 64'(out_valid),  64'(vecs[i].e_ov));
         chk("occupancy", i, 64'(occupancy),  64'(vecs[i].e_occ));
         chk("out_data",  i, out_data,        vecs[i].e_data);
         chk("stall_cnt", i, 64'(stall_cnt),  64'(vecs[i].e_st));
         chk("bubble_cnt",i, 64'(bubble_cnt), 64'(vecs[i].e_bb));
      end

      // bubble counter saturation at 15
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
         step();
         chk("sat_bubble", i, 64'(bubble_cnt), 64'((i + 1 > 15) ? 15 : i + 1));
      end
      drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1);
      step();
      chk("sat_clr", 0, 64'(bubble_cnt), 64'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
      step();
      chk("sat_after_clr", 0, 64'(bubble_cnt), 64'd1);

      // reset while FULL
      drive(1'b1, 1'b0, 1'b0, 1'b1, 64'h21, 1'b0);
      step();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 64'h22, 1'b0);
      step();
      chk("mid_occ", 0, 64'(occupancy), 64'd2);
      chk("mid_stall", 0, 64'(stall_cnt), 64'd1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h23, 1'b0);
      step();
      chk("rst_ir",   0, 64'(in_ready),   64'd1);
      chk("rst_ov",   0, 64'(out_valid),  64'd0);
      chk("rst_occ",  0, 64'(occupancy),  64'd0);
      chk("rst_data", 0, out_data,        RD);
      chk("rst_st",   0, 64'(stall_cnt),  64'd0);
      chk("rst_bb",   0, 64'(bubble_cnt), 64'd0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
         step();
         chk("post_rst_ov",   i, 64'(out_valid), 64'd0);
         chk("post_rst_data", i, out_data,       RD);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
